// File: rtl/bist_response_checker.sv
// BIST response checker: masked compare of DUT responses against expected data, with
// saturating error count, first-failure capture and an end-of-session pass/fail verdict.
module bist_response_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Valid_in,
  input  logic             Last,
  input  logic [WIDTH-1:0] From_Logic_Y,
  input  logic [WIDTH-1:0] From_data_buf,
  input  logic [WIDTH-1:0] Mask,
  output logic             Error_pulse,
  output logic             Error_flag,
  output logic [CNT_W-1:0] Error_count,
  output logic [IDX_W-1:0] First_fail_idx,
  output logic [WIDTH-1:0] First_fail_diff,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: a vector is consumed on a rising edge where Valid_in=1, the FSM is in RUN
  // and Start=0; there is no back-pressure, so Busy doubles as the ready indication.

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             pulse_n, flag_n;
  logic [CNT_W-1:0] count_n;
  logic [IDX_W-1:0] ffi_n;
  logic [WIDTH-1:0] ffd_n;
  logic [WIDTH-1:0] diff;
  logic             mismatch;
  logic             accept;

  assign diff      = (From_Logic_Y ^ From_data_buf) & ~Mask;
  assign mismatch  = |diff;
  assign accept    = (state == RUN) && Valid_in && !Start;
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    pulse_n = 1'b0;
    flag_n  = Error_flag;
    count_n = Error_count;
    ffi_n   = First_fail_idx;
    ffd_n   = First_fail_diff;
    if (Start) begin
      state_n = RUN;
      idx_n   = '0;
      flag_n  = 1'b0;
      count_n = '0;
      ffi_n   = '0;
      ffd_n   = '0;
    end else if (accept) begin
      pulse_n = mismatch;
      idx_n   = idx + IDX_W'(1);
      if (mismatch) begin
        flag_n = 1'b1;
        if (Error_count != {CNT_W{1'b1}}) count_n = Error_count + CNT_W'(1);
        // Only the first failure of a session is captured.
        if (!Error_flag) begin
          ffi_n = idx;
          ffd_n = diff;
        end
      end
      if (Last) state_n = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      Error_pulse     <= 1'b0;
      Error_flag      <= 1'b0;
      Error_count     <= '0;
      First_fail_idx  <= '0;
      First_fail_diff <= '0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      Pass            <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      Error_pulse     <= pulse_n;
      Error_flag      <= flag_n;
      Error_count     <= count_n;
      First_fail_idx  <= ffi_n;
      First_fail_diff <= ffd_n;
      Busy            <= (state_n == RUN);
      Done            <= (state_n == DONE);
      Pass            <= (state_n == DONE) && !flag_n;
    end
  end

endmodule
